// File: rtl/seq_divider_if.sv
// Request/result bundle between the EX-stage pipeline (master) and the sequential divider (slave).
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock, quotient -> LO, remainder -> HI.
// Optional macro SIGNED_DIV_EN adds signed operands via a FIX state (latency 34 instead of 33).
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  div_if
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, quo_q, den_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dbz_q;

    logic             accept, last_iter, div_zero, fits;
    logic [WIDTH-1:0] a_mag, b_mag, rem_step, quo_step;
    logic [WIDTH:0]   r_wide, diff;

    assign accept    = (state_q == IDLE) && div_if.start;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    assign div_zero  = (div_if.divisor == '0);

`ifdef SIGNED_DIV_EN
    logic q_neg_q, r_neg_q;
    logic q_neg_d, r_neg_d, b_neg;

    always_comb begin
        r_neg_d = div_if.signed_op & div_if.dividend[WIDTH-1];
        b_neg   = div_if.signed_op & div_if.divisor[WIDTH-1];
        q_neg_d = r_neg_d ^ b_neg;
        a_mag   = r_neg_d ? -div_if.dividend : div_if.dividend;
        b_mag   = b_neg   ? -div_if.divisor  : div_if.divisor;
    end
`else
    logic unused_signed_op;
    assign unused_signed_op = div_if.signed_op;

    always_comb begin
        a_mag = div_if.dividend;
        b_mag = div_if.divisor;
    end
`endif

    // Shift in the next dividend bit; the extra top bit makes the borrow the compare result.
    always_comb begin
        r_wide   = {rem_q, quo_q[WIDTH-1]};
        diff     = r_wide - {1'b0, den_q};
        fits     = ~diff[WIDTH];
        rem_step = fits ? diff[WIDTH-1:0] : r_wide[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (div_if.start) state_d = div_zero ? DONE : RUN;
`ifdef SIGNED_DIV_EN
            RUN:  if (last_iter) state_d = FIX;
`else
            RUN:  if (last_iter) state_d = DONE;
`endif
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_if.busy = (state_q == RUN) || (state_q == FIX);
        div_if.done = (state_q == DONE);
    end

    assign div_if.quotient    = quotient_q;
    assign div_if.remainder   = remainder_q;
    assign div_if.div_by_zero = dbz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            quo_q       <= '0;
            den_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                rem_q <= '0;
                quo_q <= a_mag;
                den_q <= b_mag;
                cnt_q <= '0;
                dbz_q <= div_zero;
`ifdef SIGNED_DIV_EN
                q_neg_q <= q_neg_d;
                r_neg_q <= r_neg_d;
`endif
                // Divide by zero is resolved at accept; the raw dividend goes to HI.
                if (div_zero) begin
                    quotient_q  <= '1;
                    remainder_q <= div_if.dividend;
                end
            end else if (state_q == RUN) begin
                rem_q <= rem_step;
                quo_q <= quo_step;
                cnt_q <= cnt_q + 1'b1;
`ifndef SIGNED_DIV_EN
                if (last_iter) begin
                    quotient_q  <= quo_step;
                    remainder_q <= rem_step;
                end
`endif
            end
`ifdef SIGNED_DIV_EN
            else if (state_q == FIX) begin
                quotient_q  <= q_neg_q ? -quo_q : quo_q;
                remainder_q <= r_neg_q ? -rem_q : rem_q;
            end
`endif
        end
    end
endmodule
